// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer: latches the address-phase slave select for the data
// phase, steers the selected slave's ready/response/read data, and hosts the default slave.
module ahblite_slave_mux (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  HTRANS,
   input  logic        Port0_en,
   input  logic        Port1_en,
   input  logic        Port2_en,
   input  logic        Port3_en,
   input  logic        Port4_en,
   input  logic        P0_HSEL,
   input  logic        P1_HSEL,
   input  logic        P2_HSEL,
   input  logic        P3_HSEL,
   input  logic        P4_HSEL,
   input  logic        P0_HREADYOUT,
   input  logic        P1_HREADYOUT,
   input  logic        P2_HREADYOUT,
   input  logic        P3_HREADYOUT,
   input  logic        P4_HREADYOUT,
   input  logic        P0_HRESP,
   input  logic        P1_HRESP,
   input  logic        P2_HRESP,
   input  logic        P3_HRESP,
   input  logic        P4_HRESP,
   input  logic [31:0] P0_HRDATA,
   input  logic [31:0] P1_HRDATA,
   input  logic [31:0] P2_HRDATA,
   input  logic [31:0] P3_HRDATA,
   input  logic [31:0] P4_HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } dflt_state_e;

   dflt_state_e state_q, state_d;
   logic [5:0]  sel_q, sel_d;
   logic [5:0]  addr_sel_s;
   logic [4:0]  eff_sel_s;
   logic        active_s;
   logic        unmapped_xfer_s;
   logic        dflt_ready_s;
   logic        dflt_resp_s;

   assign eff_sel_s = {P4_HSEL & Port4_en, P3_HSEL & Port3_en, P2_HSEL & Port2_en,
                       P1_HSEL & Port1_en, P0_HSEL & Port0_en};
   assign active_s  = (HTRANS == 2'b10) | (HTRANS == 2'b11);

   // Address-phase select, lowest-index port wins, default slave when nothing decodes
   always_comb begin
      addr_sel_s = 6'b000000;
      if (eff_sel_s[0]) begin
         addr_sel_s = 6'b000001;
      end else if (eff_sel_s[1]) begin
         addr_sel_s = 6'b000010;
      end else if (eff_sel_s[2]) begin
         addr_sel_s = 6'b000100;
      end else if (eff_sel_s[3]) begin
         addr_sel_s = 6'b001000;
      end else if (eff_sel_s[4]) begin
         addr_sel_s = 6'b010000;
      end else begin
         addr_sel_s = 6'b100000;
      end
   end

   assign unmapped_xfer_s = HREADY & addr_sel_s[5] & active_s;

   // Default slave next state; ERR1 always advances because it is the wait cycle itself
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (unmapped_xfer_s) begin
               state_d = ST_ERR1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: begin
            if (unmapped_xfer_s) begin
               state_d = ST_ERR1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data-phase select advances only when the current data phase completes
   always_comb begin
      sel_d = sel_q;
      if (HREADY) begin
         sel_d = addr_sel_s;
      end else begin
         sel_d = sel_q;
      end
   end

   // State and select registers with synchronous reset
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         sel_q   <= 6'b000000;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   assign dflt_ready_s = (state_q != ST_ERR1);
   assign dflt_resp_s  = (state_q != ST_IDLE);

   // Response steering; no data phase outstanding reads as a zero-wait OKAY
   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = 32'h0000_0000;
      case (sel_q)
         6'b000001: begin HREADY = P0_HREADYOUT; HRESP = P0_HRESP; HRDATA = P0_HRDATA; end
         6'b000010: begin HREADY = P1_HREADYOUT; HRESP = P1_HRESP; HRDATA = P1_HRDATA; end
         6'b000100: begin HREADY = P2_HREADYOUT; HRESP = P2_HRESP; HRDATA = P2_HRDATA; end
         6'b001000: begin HREADY = P3_HREADYOUT; HRESP = P3_HRESP; HRDATA = P3_HRDATA; end
         6'b010000: begin HREADY = P4_HREADYOUT; HRESP = P4_HRESP; HRDATA = P4_HRDATA; end
         6'b100000: begin HREADY = dflt_ready_s; HRESP = dflt_resp_s; HRDATA = 32'h0000_0000; end
         default:   begin HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0000_0000; end
      endcase
   end

endmodule
